// File: rtl/phase_detector_tdc_sync_if.sv
// Control and result signals of the clocked phase detector.
// The master modport drives the inputs; the slave modport is the detector itself.
interface phase_detector_tdc_sync_if #(
  parameter int WIDTH = 8
);
  logic             enable_i;
  logic             reference_i;
  logic             generated_i;
  logic [WIDTH-1:0] pd_clock_cycles_o;
  logic             pd_valid_o;
  logic             slip_o;

  modport master (
    output enable_i, reference_i, generated_i,
    input  pd_clock_cycles_o, pd_valid_o, slip_o
  );

  modport slave (
    input  enable_i, reference_i, generated_i,
    output pd_clock_cycles_o, pd_valid_o, slip_o
  );
endinterface

// File: rtl/phase_detector_tdc_sync.sv
// Clocked time-to-digital phase detector: signed reference/generated edge spacing
// in fpga_clk_i cycles, with slip detection, saturation and optional averaging.
module phase_detector_tdc_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 0
) (
  input logic                     fpga_clk_i,
  input logic                     reset_n_i,
  phase_detector_tdc_sync_if.slave pd_if
);
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam logic [MW-1:0]    MASK_DONE   = MW'(SYNC_STAGES + 1);
  localparam logic [WIDTH-2:0] CNT_MAX     = '1;
  localparam logic [WIDTH-2:0] CNT_ONE     = (WIDTH-1)'(1);
  localparam logic [CW-1:0]    LAST_SAMPLE = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, REF_LEAD, GEN_LEAD} state_t;

  logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d, gen_sync_q, gen_sync_d;
  logic                   ref_hist_q, ref_hist_d, gen_hist_q, gen_hist_d;
  logic [MW-1:0]          mask_q, mask_d;
  state_t                 state_q, state_d;
  logic [WIDTH-2:0]       cnt_q, cnt_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          nsamp_q, nsamp_d;
  logic                   win_slip_q, win_slip_d;
  logic [WIDTH-1:0]       pd_q, pd_d;
  logic                   valid_q, valid_d;
  logic                   slip_q, slip_d;

  logic                   armed, ref_rise, gen_rise;
  logic                   meas_valid, meas_slip, cnt_sat;
  logic signed [WIDTH-1:0] meas_val;
  logic [WIDTH-2:0]       cnt_inc;
  logic signed [AW-1:0]   sum, avg;

  // The history flop keeps tracking during the post-reset mask, so a level
  // that was already high at release never looks like a fresh edge.
  always_comb begin
    ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], pd_if.reference_i};
    gen_sync_d = {gen_sync_q[SYNC_STAGES-2:0], pd_if.generated_i};
    ref_hist_d = ref_sync_q[SYNC_STAGES-1];
    gen_hist_d = gen_sync_q[SYNC_STAGES-1];
    armed      = (mask_q == MASK_DONE);
    mask_d     = armed ? mask_q : mask_q + MW'(1);
    ref_rise   = armed & ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q;
    gen_rise   = armed & gen_sync_q[SYNC_STAGES-1] & ~gen_hist_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    meas_valid = 1'b0;
    meas_val   = '0;
    meas_slip  = 1'b0;
    cnt_sat    = (cnt_q == CNT_MAX);
    cnt_inc    = cnt_sat ? cnt_q : cnt_q + CNT_ONE;
    unique case (state_q)
      IDLE: begin
        if (ref_rise && gen_rise) begin
          meas_valid = 1'b1;
        end else if (ref_rise) begin
          cnt_d   = CNT_ONE;
          state_d = REF_LEAD;
        end else if (gen_rise) begin
          cnt_d   = CNT_ONE;
          state_d = GEN_LEAD;
        end
      end
      REF_LEAD: begin
        if (gen_rise) begin
          meas_valid = 1'b1;
          meas_val   = {1'b0, cnt_q};
          meas_slip  = cnt_sat;
          if (ref_rise) begin
            cnt_d = CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (ref_rise) begin
          meas_valid = 1'b1;
          meas_val   = {1'b0, CNT_MAX};
          meas_slip  = 1'b1;
          cnt_d      = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GEN_LEAD: begin
        if (ref_rise) begin
          meas_valid = 1'b1;
          meas_val   = -{1'b0, cnt_q};
          meas_slip  = cnt_sat;
          if (gen_rise) begin
            cnt_d = CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (gen_rise) begin
          meas_valid = 1'b1;
          meas_val   = -{1'b0, CNT_MAX};
          meas_slip  = 1'b1;
          cnt_d      = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!pd_if.enable_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      meas_valid = 1'b0;
    end
  end

  // With AVG_LOG2 = 0 the accumulator is always zero and every sample is the last.
  always_comb begin
    sum        = acc_q + AW'(meas_val);
    avg        = sum >>> AVG_LOG2;
    acc_d      = acc_q;
    nsamp_d    = nsamp_q;
    win_slip_d = win_slip_q;
    pd_d       = pd_q;
    valid_d    = 1'b0;
    slip_d     = slip_q;
    if (!pd_if.enable_i) begin
      acc_d      = '0;
      nsamp_d    = '0;
      win_slip_d = 1'b0;
    end else if (meas_valid) begin
      if (nsamp_q == LAST_SAMPLE) begin
        pd_d       = avg[WIDTH-1:0];
        valid_d    = 1'b1;
        slip_d     = win_slip_q | meas_slip;
        acc_d      = '0;
        nsamp_d    = '0;
        win_slip_d = 1'b0;
      end else begin
        acc_d      = sum;
        nsamp_d    = nsamp_q + CW'(1);
        win_slip_d = win_slip_q | meas_slip;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ref_sync_q <= '0;
      gen_sync_q <= '0;
      ref_hist_q <= 1'b0;
      gen_hist_q <= 1'b0;
      mask_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      nsamp_q    <= '0;
      win_slip_q <= 1'b0;
      pd_q       <= '0;
      valid_q    <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      ref_sync_q <= ref_sync_d;
      gen_sync_q <= gen_sync_d;
      ref_hist_q <= ref_hist_d;
      gen_hist_q <= gen_hist_d;
      mask_q     <= mask_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      nsamp_q    <= nsamp_d;
      win_slip_q <= win_slip_d;
      pd_q       <= pd_d;
      valid_q    <= valid_d;
      slip_q     <= slip_d;
    end
  end

  assign pd_if.pd_clock_cycles_o = pd_q;
  assign pd_if.pd_valid_o        = valid_q;
  assign pd_if.slip_o            = slip_q;
endmodule

// File: tb/tb_phase_detector_tdc_sync.sv
// Scoreboard bench: one stimulus stream drives a direct-output detector and a
// 4-sample averaging detector; an edge-time reference model predicts both.
module tb_phase_detector_tdc_sync;
  localparam int WIDTH = 8;
  localparam int MAXV  = 127;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_detector_tdc_sync_if #(.WIDTH(WIDTH)) if0 ();
  phase_detector_tdc_sync_if #(.WIDTH(WIDTH)) if2 ();

  phase_detector_tdc_sync #(.WIDTH(WIDTH), .SYNC_STAGES(2), .AVG_LOG2(0)) dut0 (
    .fpga_clk_i(clk), .reset_n_i(rst_n), .pd_if(if0));
  phase_detector_tdc_sync #(.WIDTH(WIDTH), .SYNC_STAGES(3), .AVG_LOG2(2)) dut2 (
    .fpga_clk_i(clk), .reset_n_i(rst_n), .pd_if(if2));

  typedef struct { int val; bit slip; } exp_t;
  exp_t q0[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: which channel opened the pending measurement and when.
  int   t = 0;
  int   open_dir = 0;
  int   open_t = 0;
  int   win_sum = 0;
  int   win_n = 0;
  bit   win_slip = 1'b0;
  logic r_prev = 1'b0, g_prev = 1'b0;
  logic en_now = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int run_len();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(100, 180));
    return int'($urandom_range(2, 30));
  endfunction

  task automatic clear_model();
    open_dir = 0;
    win_sum  = 0;
    win_n    = 0;
    win_slip = 1'b0;
  endtask

  task automatic emit(input int v, input bit s);
    q0.push_back('{v, s});
    win_sum  += v;
    win_slip |= s;
    win_n++;
    if (win_n == 4) begin
      q2.push_back('{win_sum >>> 2, win_slip});
      win_sum  = 0;
      win_n    = 0;
      win_slip = 1'b0;
    end
  endtask

  task automatic model_edge(input bit rr, input bit gr);
    int el;
    el = t - open_t;
    if (el > MAXV) el = MAXV;
    if (open_dir == 0) begin
      if (rr && gr) emit(0, 1'b0);
      else if (rr) begin open_dir = 1;  open_t = t; end
      else if (gr) begin open_dir = -1; open_t = t; end
    end else if (open_dir == 1) begin
      if (gr) begin
        emit(el, el == MAXV);
        if (rr) open_t = t; else open_dir = 0;
      end else if (rr) begin
        emit(MAXV, 1'b1);
        open_t = t;
      end
    end else begin
      if (rr) begin
        emit(-el, el == MAXV);
        if (gr) open_t = t; else open_dir = 0;
      end else if (gr) begin
        emit(-MAXV, 1'b1);
        open_t = t;
      end
    end
  endtask

  task automatic drive_raw(input logic r, input logic g);
    if0.reference_i = r;  if2.reference_i = r;
    if0.generated_i = g;  if2.generated_i = g;
    if0.enable_i = en_now; if2.enable_i = en_now;
  endtask

  task automatic step(input logic r, input logic g);
    @(negedge clk);
    drive_raw(r, g);
    if (!en_now) clear_model();
    else model_edge(r && !r_prev, g && !g_prev);
    r_prev = r;
    g_prev = g;
    t++;
  endtask

  // Reference rises at a, generated at b, so the spacing is d = b - a.
  task automatic meas(input int d);
    int a, b, len;
    a = (d >= 0) ? 0 : -d;
    b = (d >= 0) ? d : 0;
    len = ((a > b) ? a : b) + 3;
    for (int i = 0; i < len; i++) step(i >= a, i >= b);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
  endtask

  task automatic play(input logic [63:0] rb, input logic [63:0] gb, input int n);
    for (int i = 0; i < n; i++) step(rb[i], gb[i]);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    chk("drain_direct_pending", q0.size(), 0);
    chk("drain_avg_pending", q2.size(), 0);
  endtask

  // Monitor: pops on every strobe, otherwise checks that outputs hold.
  int  last0 = 0, last2 = 0;
  bit  lslip0 = 1'b0, lslip2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last0 = 0; last2 = 0; lslip0 = 1'b0; lslip2 = 1'b0;
      chk("reset_valid_direct", int'(if0.pd_valid_o), 0);
      chk("reset_valid_avg", int'(if2.pd_valid_o), 0);
      chk("reset_value_direct", int'($signed(if0.pd_clock_cycles_o)), 0);
      chk("reset_slip_avg", int'(if2.slip_o), 0);
    end else begin
      if (if0.pd_valid_o) begin
        if (q0.size() == 0) chk("direct_unexpected_strobe", 1, 0);
        else begin
          e = q0.pop_front();
          chk("direct_value", int'($signed(if0.pd_clock_cycles_o)), e.val);
          chk("direct_slip", int'(if0.slip_o), int'(e.slip));
          last0 = e.val; lslip0 = e.slip;
        end
      end else begin
        chk("direct_hold_value", int'($signed(if0.pd_clock_cycles_o)), last0);
        chk("direct_hold_slip", int'(if0.slip_o), int'(lslip0));
      end
      if (if2.pd_valid_o) begin
        if (q2.size() == 0) chk("avg_unexpected_strobe", 1, 0);
        else begin
          e = q2.pop_front();
          chk("avg_value", int'($signed(if2.pd_clock_cycles_o)), e.val);
          chk("avg_slip", int'(if2.slip_o), int'(e.slip));
          last2 = e.val; lslip2 = e.slip;
        end
      end else begin
        chk("avg_hold_value", int'($signed(if2.pd_clock_cycles_o)), last2);
        chk("avg_hold_slip", int'(if2.slip_o), int'(lslip2));
      end
    end
  end

  initial begin
    logic r_lvl, g_lvl;
    int   r_left, g_left;
    drive_raw(1'b0, 1'b0);
    // Inputs toggle under reset; release with reference already high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_raw(logic'(i[1]), logic'((i % 3) == 0));
    end
    @(negedge clk);
    drive_raw(1'b1, 1'b0);
    r_prev = 1'b1; g_prev = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

    // Averaging windows start aligned here: +4,+5,-2,+6 then -1,-1,-1,0.
    meas(4); meas(5); meas(-2); meas(6);
    meas(-1); meas(-1); meas(-1); meas(0);
    meas(5); meas(-3); meas(0);
    meas(200); meas(-200); meas(127); meas(126);
    play(bits(0, 4) | bits(10, 19), bits(14, 19), 20);
    play(bits(14, 19), bits(0, 4) | bits(10, 19), 20);
    play(bits(0, 2) | bits(6, 14), bits(6, 8) | bits(11, 14), 15);
    play(bits(6, 8) | bits(11, 14), bits(0, 2) | bits(6, 14), 15);

    // Enable dropped while a reference-led measurement is open.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    en_now = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    en_now = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    meas(7);
    drain();

    // Reset in the middle of an open measurement.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    clear_model();
    drive_raw(1'b0, 1'b0);
    r_prev = 1'b0; g_prev = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    meas(4); meas(4); meas(4); meas(-3);

    // Random independent waveforms, high and low times of at least 2 cycles.
    r_lvl = 1'b0; g_lvl = 1'b0;
    r_left = run_len(); g_left = run_len();
    for (int i = 0; i < 4000; i++) begin
      step(r_lvl, g_lvl);
      r_left = r_left - 1;
      g_left = g_left - 1;
      if (r_left == 0) begin r_lvl = ~r_lvl; r_left = run_len(); end
      if (g_left == 0) begin g_lvl = ~g_lvl; g_left = run_len(); end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_detector_tdc_sync.md
# phase_detector_tdc_sync

Synchronous, parametrised time-to-digital phase detector for the ADPLL loop. It measures the signed spacing between rising edges of the reference and generated signals in fpga_clk_i cycles, detects cycle slips, and saturates symmetrically. It can optionally average 2^AVG_LOG2 measurements before presenting a registered result with a valid strobe to the loop filter. It replaces the free-running delay-line detector wherever a deterministic, clocked error word is required.

## Interface
- WIDTH, default 8: output width, signed two's complement; MAX = 2^(WIDTH-1)-1.
- SYNC_STAGES, default 2: synchroniser depth per input, minimum 2.
- AVG_LOG2, default 0: log2 of the number of measurements averaged per output; 0 disables averaging.
- fpga_clk_i  input  1  sole clock; all state changes on its rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  measurement enable, synchronous.
- reference_i  input  1  reference signal, asynchronous to fpga_clk_i.
- generated_i  input  1  DCO output, asynchronous to fpga_clk_i.
- pd_clock_cycles_o  output  WIDTH  signed phase error. Positive means the reference leads (generated is late).
- pd_valid_o  output  1  one-cycle strobe; pd_clock_cycles_o is new in that cycle.
- slip_o  output  1  updated with each result; 1 if any measurement in the window slipped or saturated.

## Operation
- Reset values: pd_clock_cycles_o = 0, pd_valid_o = 0, slip_o = 0, FSM in IDLE, accumulator and sample count = 0, synchronisers = 0.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops plus one history flop.
  - rise = sync_out & ~history, a one-cycle pulse.
  - Both channels have identical latency.
  - Edges are masked for SYNC_STAGES+1 cycles after reset release, so an input already high at release raises no pulse.
- FSM states: IDLE, REF_LEAD, GEN_LEAD. cnt is WIDTH-1 bits, unsigned.
- IDLE:
  - ref_rise & gen_rise: emit measurement 0, stay in IDLE.
  - ref_rise only: cnt = 1, go to REF_LEAD.
  - gen_rise only: cnt = 1, go to GEN_LEAD.
- REF_LEAD:
  - gen_rise: emit +cnt, go to IDLE.
  - Otherwise cnt = min(cnt+1, MAX). Reaching MAX marks the measurement saturated.
- GEN_LEAD: mirror of REF_LEAD; the closing event is ref_rise and the emitted value is -cnt.
- Cycle slip:
  - In REF_LEAD, a ref_rise without gen_rise emits +MAX with slip set, reloads cnt = 1 and stays in REF_LEAD.
  - GEN_LEAD mirrors this and emits -MAX.
- Simultaneous closing and opening edges in REF_LEAD (gen_rise & ref_rise):
  - Emit +cnt, not a slip.
  - The ref_rise opens a new measurement: cnt = 1, stay in REF_LEAD.
  - GEN_LEAD mirrors this.
- Range: results lie in [-MAX, +MAX]. -2^(WIDTH-1) is never produced.
- Averaging (AVG_LOG2 > 0):
  - Each emitted measurement is added to a signed accumulator of WIDTH+AVG_LOG2 bits.
  - The sample count increments with each measurement.
  - On the 2^AVG_LOG2-th measurement: output = (accumulator + measurement) >>> AVG_LOG2, an arithmetic shift (floor). The accumulator and count then clear.
  - slip_o is the OR of slip/saturation flags over the window.
- AVG_LOG2 = 0: each measurement is output directly.
- Outputs hold their value between strobes.
- enable_i low:
  - Next cycle the FSM goes to IDLE; cnt, accumulator and sample count clear.
  - No strobe is generated.
  - pd_clock_cycles_o and slip_o hold.
  - A measurement closing in the same cycle enable_i falls is discarded.
- Reset mid-measurement: asynchronous return to reset values. No partial result is emitted.

## Timing
- An input edge first sampled high at clock n produces its rise pulse at clock n+SYNC_STAGES.
- Measured value = difference in sample cycles between the two edges, quantised to 1 cycle, ±1 cycle from metastability resolution.
- pd_valid_o asserts on the clock after the closing rise pulse (a registered output). Total input-to-strobe latency is SYNC_STAGES+1 cycles.
- Minimum spacing between strobes is 1 cycle: back-to-back measurements are accepted without loss.
- The FSM handles an edge on every cycle; no input edges are dropped while enable_i is high.
- Input pulse high and low times must each be at least 2 cycles of fpga_clk_i, or edges merge.

## Test plan
- Reset asserted with inputs toggling: all outputs 0. Release with reference_i already high: no strobe.
- Reference rises, generated rises 5 cycles later (WIDTH=8): one strobe at closing rise + 1, value +5, slip_o 0. Generated leads by 3: value -3.
- Both rise in the same sample cycle: strobe with value 0. Reference 200 cycles ahead: value +127, slip_o 1.
- Two reference edges 10 cycles apart with no generated edge, then generated 4 cycles after the second: strobes +127 with slip_o 1, then +4 with slip_o 0.
- AVG_LOG2=2, measurements +4, +5, -2, +6: a single strobe after the 4th, value 3 (13 >>> 2); measurements -1, -1, -1, 0: value -1.
- enable_i dropped 2 cycles into REF_LEAD, then restored: no strobe, output holds. The next clean 7-cycle lead gives +7.
